// File: rtl/instr_mem_loader_pkg.sv
// Shared types and helpers for the instruction memory loader.
package instr_loader_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} loader_state_t;

   function automatic int unsigned bytes_per_word(input int unsigned data_width);
      return data_width / 8;
   endfunction

   function automatic bit width_is_byte_multiple(input int unsigned data_width);
      return (data_width % 8) == 0;
   endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host byte link, control/status and instruction-memory write port of the loader.
interface instr_mem_loader_if #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 32
);
   logic                     start;
   logic [ADDRESS_WIDTH:0]   len;
   logic [7:0]               in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic                     WE;
   logic [ADDRESS_WIDTH-1:0] WA;
   logic [DATA_WIDTH-1:0]    WD;
   logic                     busy;
   logic                     done;
   logic                     cpu_rst_n;

   modport slave (
      input  start, len, in_data, in_valid,
      output in_ready, WE, WA, WD, busy, done, cpu_rst_n
   );

   modport master (
      output start, len, in_data, in_valid,
      input  in_ready, WE, WA, WD, busy, done, cpu_rst_n
   );
endinterface

// File: rtl/instr_mem_loader_word_packer.sv
// Little-endian byte-to-word packer; word presents the current byte already inserted.
module word_packer
   import instr_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  byte_en,
   input  logic [7:0]            in_data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_full
);
   localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);
   localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CW-1:0] LAST = CW'(BPW - 1);

   logic [CW-1:0]         r_byte_cnt;
   logic [DATA_WIDTH-1:0] r_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (clear) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (byte_en) begin
         r_word[{r_byte_cnt, 3'b000} +: 8] <= in_data;
         r_byte_cnt <= (r_byte_cnt == LAST) ? '0 : r_byte_cnt + 1'b1;
      end
   end

   // Bypass the completing byte so the write data is ready on the same edge.
   always_comb begin
      word = r_word;
      if (byte_en) word[{r_byte_cnt, 3'b000} +: 8] = in_data;
   end

   assign word_full = byte_en && (r_byte_cnt == LAST);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte-streamed program into instruction memory and holds the CPU in reset until done.
module instr_mem_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input logic               clk,
   input logic               rst_n,
   instr_mem_loader_if.slave bus
);
   localparam int unsigned BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
   localparam logic [ADDRESS_WIDTH:0] MAX_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   if (!width_is_byte_multiple(DATA_WIDTH) || BYTES_PER_WORD == 0) begin : g_bad_width
      $error("instr_mem_loader: DATA_WIDTH must be a non-zero multiple of 8");
   end

   loader_state_t            r_state;
   logic [ADDRESS_WIDTH:0]   r_len_q;
   logic [ADDRESS_WIDTH:0]   r_word_cnt;
   logic                     r_we;
   logic [ADDRESS_WIDTH-1:0] r_wa;
   logic [DATA_WIDTH-1:0]    r_wd;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_cpu_rst_n;

   logic                     w_can_start;
   logic                     w_clear;
   logic                     w_byte_en;
   logic                     w_word_full;
   logic [DATA_WIDTH-1:0]    w_word;
   logic [ADDRESS_WIDTH:0]   w_len_clamped;
   logic [ADDRESS_WIDTH:0]   w_cnt_next;

   assign w_can_start   = (r_state == IDLE) || (r_state == DONE);
   assign w_clear       = w_can_start && bus.start && (bus.len != '0);
   assign w_byte_en     = (r_state == LOAD) && bus.in_valid;
   assign w_len_clamped = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
   assign w_cnt_next    = r_word_cnt + 1'b1;

   word_packer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (w_clear),
      .byte_en  (w_byte_en),
      .in_data  (bus.in_data),
      .word     (w_word),
      .word_full(w_word_full)
   );

   // The word counter doubles as the write address; its extra MSB lets a
   // full-depth load finish without the address wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_len_q     <= '0;
         r_word_cnt  <= '0;
         r_we        <= 1'b0;
         r_wa        <= '0;
         r_wd        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cpu_rst_n <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_we <= 1'b0;
               if (bus.start) begin
                  if (bus.len == '0) begin
                     r_state     <= DONE;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_cpu_rst_n <= 1'b1;
                  end else begin
                     r_state     <= LOAD;
                     r_len_q     <= w_len_clamped;
                     r_word_cnt  <= '0;
                     r_busy      <= 1'b1;
                     r_done      <= 1'b0;
                     r_cpu_rst_n <= 1'b0;
                  end
               end
            end
            LOAD: begin
               if (w_word_full) begin
                  r_state <= WRITE;
                  r_we    <= 1'b1;
                  r_wa    <= r_word_cnt[ADDRESS_WIDTH-1:0];
                  r_wd    <= w_word;
               end
            end
            WRITE: begin
               r_we       <= 1'b0;
               r_word_cnt <= w_cnt_next;
               if (w_cnt_next == r_len_q) begin
                  r_state     <= DONE;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_cpu_rst_n <= 1'b1;
               end else begin
                  r_state <= LOAD;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == LOAD);
   assign bus.WE        = r_we;
   assign bus.WA        = r_wa;
   assign bus.WD        = r_wd;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.cpu_rst_n = r_cpu_rst_n;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart to the instruction ROM. It receives a program as a byte stream over a valid/ready handshake and packs the bytes little-endian into DATA_WIDTH words.
- It drives the synchronous write port (WE/WA/WD) of the writable instruction memory.
- It holds the CPU in reset until the programmed word count has been written.
- It sits between the host byte link (UART receiver or testbench) and the instruction memory.

Parameters:
- ADDRESS_WIDTH, 8, word-address width of the instruction memory; depth is 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- BYTES_PER_WORD (localparam), DATA_WIDTH/8, bytes per word.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; sampled in IDLE or DONE only.
- len  input  ADDRESS_WIDTH+1  number of words to load; sampled with start.
- in_data  input  8  program byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- WE  output  1  instruction memory write enable.
- WA  output  ADDRESS_WIDTH  instruction memory word address.
- WD  output  DATA_WIDTH  instruction memory write data.
- busy  output  1  high in LOAD or WRITE.
- done  output  1  high in DONE.
- cpu_rst_n  output  1  active-low CPU reset; low unless in DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, WE=0, WA=0, WD=0, busy=0, done=0, cpu_rst_n=0. The byte counter, word counter and packing register are cleared.
- Reset mid-operation: any partial word is discarded and no write is issued. After release the block is in IDLE and memory contents are unchanged.
- All outputs are registered except in_ready, which decodes state (1 only in LOAD).
- State IDLE:
  - start=1, len=0 -> DONE.
  - start=1, len>0 -> LOAD. Latch len_q=min(len, 2**ADDRESS_WIDTH); clear addr, byte_cnt and word_cnt.
- State LOAD:
  - A byte transfers on a cycle with in_valid && in_ready. Byte k of the word (k=0 first) goes to packing bits [8k+7:8k], i.e. little-endian.
  - byte_cnt increments on each transfer.
  - When the transfer with byte_cnt=BYTES_PER_WORD-1 occurs -> WRITE, and byte_cnt returns to 0.
  - in_valid=0 stalls indefinitely with no timeout.
  - in_data is ignored when no transfer occurs.
- State WRITE (exactly one cycle): WE=1, WA=addr, WD=packed word, in_ready=0.
  - On the next edge, addr and word_cnt increment.
  - If word_cnt+1 == len_q -> DONE, else -> LOAD.
- State DONE: done=1, cpu_rst_n=1. WE=0, and WA/WD hold their last values.
  - start=1 re-enters a load exactly as from IDLE. cpu_rst_n drops to 0 on the same edge.
- start is ignored in LOAD and WRITE.
- Throughput is at most one word per BYTES_PER_WORD+1 cycles.
- Boundary conditions:
  - len > 2**ADDRESS_WIDTH is clamped, so addr never wraps.
  - A load of 2**ADDRESS_WIDTH words ends with the final write at WA = 2**ADDRESS_WIDTH-1.
  - Extra bytes presented after DONE are not accepted (in_ready=0).
- WE is never high in more than one consecutive cycle.

Decomposition:
- Package instr_loader_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} loader_state_t.
  - Function bytes_per_word(DATA_WIDTH), plus an elaboration-time check that DATA_WIDTH % 8 == 0.
- One sub-module, word_packer:
  - Byte-to-word shift/insert register with byte counter.
  - Inputs: clk, rst_n, clear, byte_en, in_data.
  - Outputs: word, word_full.
- The FSM, counters and write port remain in instr_mem_loader.
- The writable instruction memory is a separate block and is not part of this one.

Test Plan:
- Two-word load, continuous valid: start, len=2; bytes 13 05 10 00 93 05 20 00 -> WE at WA=0, WD=0x00100513; WE at WA=1, WD=0x00200593; done=1 and cpu_rst_n=1 one cycle after the second WE.
- Backpressure gaps: the same stream with in_valid low for 3 cycles between every byte -> identical writes and values; no WE until the 4th byte of each word transfers.
- len=0: start with len=0 -> DONE the next cycle, no WE ever, in_ready stays 0.
- Async reset mid-word: 2 of 4 bytes sent, then rst_n pulsed -> WE never asserts, all outputs at reset values. A fresh start with len=1 and bytes AA BB CC DD -> WA=0, WD=0xDDCCBBAA.
- start asserted during LOAD with len=5, while a load with len=1 is running -> ignored: exactly one WE, then DONE. A later start from DONE reloads starting at WA=0.
- Full depth, len=511 (clamped to 256): 1024 bytes -> 256 writes at WA=0..255 in order; final write at WA=255, then DONE with no address wrap.
